// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM encoding,
// counter width and address-split helpers.
package icache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    // Index width for n items; a single item still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr,
                                                      input int unsigned off_bits);
        return (addr >> 2) & ((32'd1 << off_bits) - 32'd1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                     input int unsigned off_bits,
                                                     input int unsigned idx_bits);
        return (addr >> (off_bits + 2)) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned off_bits,
                                                   input int unsigned idx_bits);
        return addr >> (off_bits + idx_bits + 2);
    endfunction

endpackage

// File: rtl/icache_way_sel.sv
// Victim pick for one set: lowest-numbered invalid way, else the round-robin pointer.
module icache_way_sel
    import icache_pkg::*;
#(
    parameter int unsigned WAYS = 2
) (
    input  logic [WAYS-1:0]          valid_i,
    input  logic [idx_w(WAYS)-1:0]   rr_i,
    output logic [idx_w(WAYS)-1:0]   victim_c_o
);

    localparam int unsigned WAY_W = idx_w(WAYS);

    // Scan downwards so the lowest invalid way is the one left standing.
    always_comb begin
        victim_c_o = rr_i;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_i[WAY_W'(w)]) begin
                victim_c_o = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/icache_comp_sa.sv
// Set-associative instruction cache with whole-line burst refill, flush,
// round-robin replacement and hit/miss counters.
module icache_comp_sa
    import icache_pkg::*;
#(
    parameter int unsigned CACHE_SIZE = 1024,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                proc_valid,
    output logic                proc_ready,
    input  logic [ADDR_W-1:0]   proc_addr,
    output logic [DATA_W-1:0]   proc_rdata,
    input  logic                flush,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic [DATA_W-1:0]   mem_req_rdata,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int unsigned SETS     = CACHE_SIZE / (4 * LINE_WORDS * WAYS);
    localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned OFF_W    = idx_w(LINE_WORDS);
    localparam int unsigned WAY_W    = idx_w(WAYS);
    localparam int unsigned TAG_W    = ADDR_W - 2 - OFF_BITS - IDX_BITS;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(4 * LINE_WORDS - 1);

    // Tag/data arrays carry no reset; validity lives in valid_q.
    logic [TAG_W-1:0]  tag_mem_q  [WAYS][SETS];
    logic [DATA_W-1:0] data_mem_q [WAYS][SETS][LINE_WORDS];
    logic [DATA_W-1:0] stage_q    [LINE_WORDS];
    logic [WAYS-1:0]   valid_q    [SETS];
    logic [WAY_W-1:0]  rr_q       [SETS];

    logic [1:0]        state_q,         state_d;
    logic [ADDR_W-1:0] line_base_q,     line_base_d;
    logic [OFF_W-1:0]  req_off_q,       req_off_d;
    logic [OFF_W-1:0]  word_q,          word_d;
    logic [WAY_W-1:0]  victim_q,        victim_d;
    logic              drop_q,          drop_d;
    logic              flush_pend_q,    flush_pend_d;
    logic              proc_ready_q,    proc_ready_d;
    logic [DATA_W-1:0] proc_rdata_q,    proc_rdata_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q,  mem_req_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q,       hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q,      miss_cnt_d;

    logic [IDX_BITS-1:0] lk_idx_c, fill_idx_c;
    logic [TAG_W-1:0]    lk_tag_c, fill_tag_c;
    logic [OFF_W-1:0]    lk_off_c;
    logic                hit_c;
    logic [WAY_W-1:0]    hit_way_c;
    logic [WAY_W-1:0]    victim_c;
    logic [DATA_W-1:0]   fill_line_c [LINE_WORDS];
    logic                last_word_c;
    logic                install_c;
    logic                flush_clr_c;

    assign lk_idx_c    = IDX_BITS'(addr_index(proc_addr, OFF_BITS, IDX_BITS));
    assign lk_tag_c    = TAG_W'(addr_tag(proc_addr, OFF_BITS, IDX_BITS));
    assign lk_off_c    = OFF_W'(addr_offset(proc_addr, OFF_BITS));
    assign fill_idx_c  = IDX_BITS'(addr_index(line_base_q, OFF_BITS, IDX_BITS));
    assign fill_tag_c  = TAG_W'(addr_tag(line_base_q, OFF_BITS, IDX_BITS));
    assign last_word_c = (word_q == OFF_W'(LINE_WORDS - 1));

    icache_way_sel #(
        .WAYS       (WAYS)
    ) u_way_sel (
        .valid_i    (valid_q[lk_idx_c]),
        .rr_i       (rr_q[lk_idx_c]),
        .victim_c_o (victim_c)
    );

    // Tag compare across every way of the indexed set.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit_c && valid_q[lk_idx_c][WAY_W'(w)] &&
                (tag_mem_q[WAY_W'(w)][lk_idx_c] == lk_tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
    end

    // Complete line as it will be installed: staged words plus the word on the bus.
    always_comb begin
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            fill_line_c[i] = (OFF_W'(i) == word_q) ? mem_req_rdata : stage_q[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        line_base_d     = line_base_q;
        req_off_d       = req_off_q;
        word_d          = word_q;
        victim_d        = victim_q;
        drop_d          = drop_q;
        flush_pend_d    = flush_pend_q;
        proc_ready_d    = 1'b0;
        proc_rdata_d    = proc_rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        install_c       = 1'b0;
        flush_clr_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d = ST_FLUSH;
                end else if (proc_valid) begin
                    if (hit_c) begin
                        proc_rdata_d = data_mem_q[hit_way_c][lk_idx_c][lk_off_c];
                        proc_ready_d = 1'b1;
                        hit_cnt_d    = hit_cnt_q + CNT_W'(1);
                        state_d      = ST_RESP;
                    end else begin
                        line_base_d     = proc_addr & ~LINE_MASK;
                        req_off_d       = lk_off_c;
                        word_d          = '0;
                        victim_d        = victim_c;
                        drop_d          = 1'b0;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = proc_addr & ~LINE_MASK;
                        miss_cnt_d      = miss_cnt_q + CNT_W'(1);
                        state_d         = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                flush_pend_d = flush_pend_q | flush;
                if (!proc_valid) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    if (last_word_c) begin
                        mem_req_valid_d = 1'b0;
                        install_c       = 1'b1;
                        // A fetch abandoned mid-burst still installs, but gets no response.
                        if (proc_valid && !drop_q) begin
                            proc_rdata_d = fill_line_c[req_off_q];
                            proc_ready_d = 1'b1;
                            state_d      = ST_RESP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        word_d         = word_q + OFF_W'(1);
                        mem_req_addr_d = line_base_q | ADDR_W'({word_q + OFF_W'(1), 2'b00});
                    end
                end
            end
            ST_RESP: begin
                flush_pend_d = flush_pend_q | flush;
                state_d      = ST_IDLE;
            end
            ST_FLUSH: begin
                flush_clr_c  = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            line_base_q     <= '0;
            req_off_q       <= '0;
            word_q          <= '0;
            victim_q        <= '0;
            drop_q          <= 1'b0;
            flush_pend_q    <= 1'b0;
            proc_ready_q    <= 1'b0;
            proc_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q         <= state_d;
            line_base_q     <= line_base_d;
            req_off_q       <= req_off_d;
            word_q          <= word_d;
            victim_q        <= victim_d;
            drop_q          <= drop_d;
            flush_pend_q    <= flush_pend_d;
            proc_ready_q    <= proc_ready_d;
            proc_rdata_q    <= proc_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            if (flush_clr_c) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else if (install_c) begin
                valid_q[fill_idx_c][victim_q] <= 1'b1;
                rr_q[fill_idx_c] <= (WAYS > 1) ? rr_q[fill_idx_c] + WAY_W'(1) : '0;
            end
        end
    end

    // Staging and array writes.
    always_ff @(posedge clk) begin
        if ((state_q == ST_REFILL) && mem_req_ready) begin
            stage_q[word_q] <= mem_req_rdata;
        end
        if (install_c) begin
            tag_mem_q[victim_q][fill_idx_c] <= fill_tag_c;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                data_mem_q[victim_q][fill_idx_c][i] <= fill_line_c[i];
            end
        end
    end

    assign proc_ready    = proc_ready_q;
    assign proc_rdata    = proc_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule

// File: doc/icache_comp_sa.md
Name: icache_comp_sa

Overview:
Parametrised set-associative instruction cache with multi-word lines. It sits between the core fetch port and the instruction memory, in place of the direct-mapped single-word cache. Each miss refills a whole line with one sequential word-burst on the existing memory request handshake. Adds a flush control, round-robin replacement and hit/miss performance counters.

Parameters:
CACHE_SIZE  1024  total data capacity in bytes; power of two
WAYS        2     associativity; 1, 2 or 4
LINE_WORDS  4     32-bit words per line; power of two, >=1
Derived:
- SETS = CACHE_SIZE/(4*LINE_WORDS*WAYS); must be >=2.
- OFF_BITS = log2(LINE_WORDS); IDX_BITS = log2(SETS).
- Address split: word offset = addr[OFF_BITS+1:2]; index = addr[IDX_BITS+OFF_BITS+1:OFF_BITS+2]; tag = the remaining upper bits.

Ports:
clk            in   1   clock, all state on rising edge
resetn         in   1   asynchronous, active-low reset
proc_valid     in   1   fetch request; held with proc_addr until proc_ready
proc_ready     out  1   one-cycle pulse; proc_rdata valid this cycle
proc_addr      in   32  byte address; bits[1:0] ignored
proc_rdata     out  32  fetched instruction word
flush          in   1   single-cycle pulse; invalidate all lines
mem_req_valid  out  1   memory word request
mem_req_ready  in   1   memory accepted request; mem_req_rdata valid this cycle
mem_req_addr   out  32  word-aligned request address
mem_req_rdata  in   32  memory read data
hit_count      out  32  lookups that hit; wraps
miss_count     out  32  lookups that missed; wraps

Behaviour:
- Reset (async, resetn=0):
  - All valid bits, round-robin pointers, counters and the flush-pending flag clear.
  - State goes to IDLE.
  - proc_ready=0, mem_req_valid=0, mem_req_addr=0, proc_rdata=0.
  - Tag and data arrays are not reset.
- States: IDLE, REFILL, RESP, FLUSH.
- IDLE:
  - If flush or flush-pending is set: go to FLUSH. This has priority over proc_valid.
  - Else if proc_valid: look up all ways of the indexed set.
    - Hit: proc_rdata <= hit word, proc_ready <= 1 in the next cycle (latency 1), hit_count++, go to RESP.
    - Miss: latch line base address, select victim, miss_count++, go to REFILL.
- RESP:
  - proc_ready is high for exactly this cycle. No new lookup is accepted.
  - Return to IDLE. Maximum hit throughput is one fetch per 2 cycles.
- REFILL:
  - Word counter w runs from 0 to LINE_WORDS-1, always in ascending order (no critical-word-first).
  - mem_req_valid=1 and mem_req_addr = line_base + 4*w. Both are stable until mem_req_ready.
  - On each cycle with mem_req_ready=1, the staging line captures word w and w increments.
  - Any number of stall cycles is allowed. mem_req_valid stays high with no gaps inside a burst.
  - On the last word:
    - mem_req_valid <= 0.
    - Write tag, data and valid into the victim way.
    - Advance that set's round-robin pointer.
    - proc_rdata <= requested word, proc_ready <= 1, go to RESP.
- Victim selection: the lowest-numbered invalid way in the set; if all ways are valid, the set's round-robin pointer.
- proc_valid dropped during REFILL: the refill completes and the line is installed. proc_ready is not pulsed; state goes to IDLE instead of RESP.
- flush during REFILL or RESP: sets flush-pending. The current transaction completes first.
- FLUSH: one cycle. Clears every valid bit and every round-robin pointer, clears flush-pending, goes to IDLE.
- Counters are not cleared by flush.
- With WAYS=1 the round-robin pointer is constant 0. Behaviour is then a direct-mapped cache with line refill.

Decomposition:
- Shared package icache_pkg holds:
  - The state encoding (IDLE/REFILL/RESP/FLUSH).
  - Address-split functions (tag/index/offset) derived from the parameters.
  - Counter width.
- One sub-module, icache_way_sel: per-set valid vector plus round-robin pointer in, victim way index out. Purely combinational victim pick; the pointer flops stay in the parent.

Test Plan (defaults: 32 sets, 16 B lines, tag=addr[31:9]):
1. Cold miss 0x0000_0104 on an empty cache, memory returns addr^0xA5A5_0000 with ready every cycle
   -> mem_req_addr sequence 0x100, 0x104, 0x108, 0x10C; proc_ready with 0xA5A5_0104; miss_count=1.
   Then fetch 0x108 -> proc_ready 1 cycle after proc_valid, no mem_req_valid, hit_count=1.
2. Fetch 0x000, 0x200, 0x400 (all set 0)
   -> the third fetch evicts way 0 (0x000); fetching 0x200 hits; fetching 0x000 misses and evicts way 1 (0x200).
3. Fill 0x100, pulse flush, fetch 0x100
   -> FLUSH takes one cycle, then a full 4-word refill occurs; miss_count increments.
4. Miss with mem_req_ready asserted every third cycle
   -> mem_req_valid/addr held stable across stalls; 4 words captured; correct proc_rdata; no early proc_ready.
5. Deassert resetn in the middle of a refill (after 2 words)
   -> mem_req_valid and proc_ready drop immediately; fetching the same address afterwards misses and refills all 4 words.
6. Drop proc_valid after the first refill word, and pulse flush during the same refill
   -> refill finishes with no proc_ready; FLUSH executes next; a subsequent fetch of that line misses.
